// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the mem_resp bus responder.
//   state_t  - responder FSM states (IDLE, ACCESS, DONE)
//   op_t     - captured operation (RD, WR)
//   req_t    - request captured at the IDLE->ACCESS edge
//   BUS_IDLE - value of an undriven active-low bus
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [15:0] data;   // true-polarity write data
    } req_t;

    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous 16-bit RAM, read-before-write.
// Ports:
//   clk  - clock
//   we   - write enable
//   addr - word address [ADDR_BITS-1:0]
//   d    - write data
//   q    - registered read data (word at addr on the previous edge)
module mem_array #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          d,
    output logic [15:0]          q
);

    logic [15:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= d;
        q <= mem[addr];
    end

endmodule

// File: rtl/mem_resp.sv
// mem_resp: memory-module bus responder with four-phase ok_ handshake.
// Ports (bus signals active low, bit 0 = MSB):
//   clk_sys - system clock
//   clr     - synchronous active-high reset
//   r_, w_  - read / write request strobes
//   nb_     - segment number [0:3]
//   ad_     - word address [0:15]
//   dt_     - write data [0:15]
//   rdt_    - read data, all ones when not driving
//   ok_     - acknowledge
//   rdy     - module accepts requests
// Optional feature: define MEM_CLEAR_EN to zero the whole array after clr
// (one word per clock, rdy low until the sweep completes).
module mem_resp
    import mem_pkg::*;
#(
    parameter int         ADDR_BITS = 12,
    parameter logic [3:0] NB        = 4'd0,
    parameter int         BASE      = 0,
    parameter int         LATENCY   = 2
) (
    input  logic        clk_sys,
    input  logic        clr,
    input  logic        r_,
    input  logic        w_,
    input  logic [0:3]  nb_,
    input  logic [0:15] ad_,
    input  logic [0:15] dt_,
    output logic [0:15] rdt_,
    output logic        ok_,
    output logic        rdy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state;
    logic [CW-1:0]         cnt;
    req_t                  req;
    logic [ADDR_BITS-1:0]  idx;

    logic [15:0]           a;
    logic                  sel;
    logic                  valid_req;
    logic                  released;
    logic                  commit;

    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [15:0]           ram_d;
    logic [15:0]           ram_q;

    // Reversed-bit-order bus maps straight onto a [15:0] vector: bus bit 0 is the MSB.
    assign a         = ~ad_;
    assign sel       = (~nb_ == NB) && ((a >> ADDR_BITS) == 16'(BASE));
    assign valid_req = sel && (r_ ^ w_);
    // Release is judged on the strobe of the captured operation only.
    assign released  = (req.op == RD) ? r_ : w_;
    // clr on the commit edge drops the write.
    assign commit    = !clr && (state == ACCESS) && !released && (cnt == '0);

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_req && rdy) begin
                        state    <= ACCESS;
                        cnt      <= CW'(LATENCY - 1);
                        req.op   <= r_ ? WR : RD;
                        req.data <= ~dt_;
                        idx      <= a[ADDR_BITS-1:0];
                    end
                end
                ACCESS: begin
                    if (released)        state <= IDLE;
                    else if (cnt == '0)  state <= DONE;
                    else                 cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    if (r_ && w_) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_CLEAR_EN
    logic [ADDR_BITS-1:0] sweep_addr;
    logic                 sweeping;

    // rdy drops with the clr edge and rises on the edge that writes the last word.
    always_ff @(posedge clk_sys) begin
        if (clr) begin
            sweeping   <= 1'b1;
            sweep_addr <= '0;
        end else if (sweeping) begin
            sweep_addr <= sweep_addr + 1'b1;
            if (&sweep_addr) sweeping <= 1'b0;
        end
    end

    assign rdy      = !sweeping;
    assign ram_we   = (sweeping && !clr) || (commit && req.op == WR);
    assign ram_addr = sweeping ? sweep_addr : idx;
    assign ram_d    = sweeping ? 16'h0000 : req.data;
`else
    assign rdy      = 1'b1;
    assign ram_we   = commit && (req.op == WR);
    assign ram_addr = idx;
    assign ram_d    = req.data;
`endif

    mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk  (clk_sys),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (ram_d),
        .q    (ram_q)
    );

    // ram_q was loaded on the ACCESS->DONE edge and holds through DONE
    // because the address does not move and nothing is written.
    assign ok_  = (state != DONE);
    assign rdt_ = (state == DONE && req.op == RD) ? ~ram_q : BUS_IDLE;

endmodule
